// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
// Shares one single-port synchronous ROM between two read requesters and
// holds off all ROM traffic until the PLL lock flag has been stable for
// LOCK_WAIT cycles. One read can be issued per cycle. Ties are broken
// round-robin. Each returned word comes back with a pulse on the vld line
// of the requester that issued it.
//
// Ports:
//   clk, rst            ROM clock (rising edge); asynchronous active-high reset
//   pll_locked          PLL lock flag, asynchronous to clk
//   req0/addr0/gnt0     requester 0 request, address, combinational grant
//   vld0                one-cycle pulse: rd_data belongs to requester 0
//   req1/addr1/gnt1     requester 1, same as above
//   vld1                one-cycle pulse: rd_data belongs to requester 1
//   rd_data             registered read data, shared by both requesters
//   rom_addr            registered address to the ROM
//   rom_q               ROM output, ROM_LAT cycles after rom_addr
//   ready               high while in RUN (also the FSM state observation point)
//
// Handshake: reqN and addrN stay stable until gntN=1 in the same cycle; the
// address is taken on that clock edge. The requester may change or drop them
// from the next cycle. Dropping reqN before it is granted issues no read.
// The data returns ROM_LAT+2 cycles after the grant cycle, marked by vldN.
// Reads still in flight when lock is lost are dropped and get no vld pulse.

module rom_read_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int ROM_LAT   = 1,
  parameter int LOCK_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              vld0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              vld1,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              ready
);

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic         sync1;
  logic         lock_s;
  logic [7:0]   cnt;
  logic         prio;              // 1: requester 1 wins a tie
  logic         flush;
  logic [ROM_LAT:0] tag_v;         // tag pipe: valid bits
  logic [ROM_LAT:0] tag_id;        // tag pipe: requester id

  // Two-flop synchronizer for the asynchronous lock flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_LOCK;
    else     state <= state_nx;
  end

  // FSM: next state.
  always_comb begin
    state_nx = state;
    case (state)
      WAIT_LOCK: if (lock_s && cnt == 8'(LOCK_WAIT - 1)) state_nx = RUN;
      RUN:       if (!lock_s) state_nx = WAIT_LOCK;
      default:   state_nx = WAIT_LOCK;
    endcase
  end

  // FSM: outputs. Grants only exist in RUN, so the cycle of the transition
  // into RUN can never carry a grant.
  always_comb begin
    ready = (state == RUN);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (state == RUN) begin
      if (req0 && (!req1 || !prio)) gnt0 = 1'b1;
      else if (req1)                gnt1 = 1'b1;
    end
  end

  // Lock-stable counter: counts consecutive lock_s cycles in WAIT_LOCK and
  // sits at 0 otherwise, so every return to WAIT_LOCK restarts the wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 8'd0;
    else if (state == WAIT_LOCK && lock_s && state_nx == WAIT_LOCK) cnt <= cnt + 8'd1;
    else cnt <= 8'd0;
  end

  // Lock lost while running: in-flight tags are discarded on the same edge
  // the FSM drops back to WAIT_LOCK.
  assign flush = (state == RUN) && !lock_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      prio     <= 1'b0;
      tag_v    <= '0;
      tag_id   <= '0;
      rd_data  <= '0;
      vld0     <= 1'b0;
      vld1     <= 1'b0;
    end else begin
      if (gnt0)      rom_addr <= addr0;
      else if (gnt1) rom_addr <= addr1;

      // The winner loses the next tie.
      if (gnt0 || gnt1) prio <= gnt0;

      if (flush) begin
        tag_v  <= '0;
        tag_id <= '0;
        vld0   <= 1'b0;
        vld1   <= 1'b0;
      end else begin
        // Tag index k is the grant made k+1 cycles ago; index ROM_LAT lines
        // up with the ROM word for that grant on rom_q.
        tag_v  <= {tag_v[ROM_LAT-1:0], gnt0 | gnt1};
        tag_id <= {tag_id[ROM_LAT-1:0], gnt1};
        vld0   <= tag_v[ROM_LAT] & ~tag_id[ROM_LAT];
        vld1   <= tag_v[ROM_LAT] & tag_id[ROM_LAT];
        if (tag_v[ROM_LAT]) rd_data <= rom_q;
      end
    end
  end

endmodule
